vc_rr_arbiter: RTL and testbench



---
 rtl/vc_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_vc_rr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_rr_arbiter.sv
// Purpose : round-robin arbiter draining up to NUM_FIFOS VC input FIFOs into one downstream FIFO.
// Latency : pop is combinational in the grant cycle; push_out/data_out/grant_idx follow exactly 1 cycle later.
// Backpressure: almost_full_out blocks new pops immediately; the single in-flight word always lands.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   enable               - arbitration permitted (control FSM in ACTIVE)
//   empty_fifo[k]        - FIFO k empty; data_in[k*DATA_WIDTH +: DATA_WIDTH] is its FWFT head
//   almost_full_out      - downstream almost-full
//   pop                  - one-hot pop strobe to the input FIFOs
//   push_out, data_out   - registered write strobe / word to downstream FIFO
//   grant_idx            - index of the FIFO popped in the previous cycle
//   arb_state            - 0 DISABLED, 1 RUN, 2 STALL
// Optional: define ARB_STRICT_PRIO_EN to make FIFOs 0..NUM_FIFOS/2-1 a strict
// high-priority class, each class round-robin with its own pointer.

module vc_rr_arbiter #(
    parameter int NUM_FIFOS  = 8,
    parameter int DATA_WIDTH = 10,
    parameter int IDX_W      = $clog2(NUM_FIFOS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_FIFOS-1:0]            empty_fifo,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] data_in,
    input  logic                            almost_full_out,
    output logic [NUM_FIFOS-1:0]            pop,
    output logic                            push_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [IDX_W-1:0]                grant_idx,
    output logic [1:0]                      arb_state
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2
    } arb_state_t;

    arb_state_t             state;
    logic                   grant_ok;
    logic                   grant;
    logic                   sel_vld;
    logic [IDX_W-1:0]       sel_idx;
    logic [DATA_WIDTH-1:0]  sel_dat;

    // Pops are also masked during reset so the FIFO bank never sees a strobe
    // on the same edge that clears it.
    assign grant_ok = (state == ST_RUN) && enable && !almost_full_out && !reset;

`ifdef ARB_STRICT_PRIO_EN
    localparam int HALF = NUM_FIFOS / 2;

    logic [IDX_W-1:0] last_hi;
    logic [IDX_W-1:0] last_lo;
    logic             hi_vld;
    logic             lo_vld;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Each class searches from its own pointer+1, wrapping inside the class.
    always_comb begin
        int c;
        c      = 0;
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = 1; i <= HALF; i++) begin
            c = (int'(last_hi) + i) % HALF;
            if (!hi_vld && !empty_fifo[c]) begin
                hi_vld = 1'b1;
                hi_idx = IDX_W'(c);
            end
            c = HALF + ((int'(last_lo) - HALF + i) % HALF);
            if (!lo_vld && !empty_fifo[c]) begin
                lo_vld = 1'b1;
                lo_idx = IDX_W'(c);
            end
        end
        sel_vld = hi_vld || lo_vld;
        sel_idx = hi_vld ? hi_idx : lo_idx;
    end
`else
    logic [IDX_W-1:0] last_grant;

    // Search starts one past the last winner; i == NUM_FIFOS revisits last_grant itself.
    always_comb begin
        int c;
        c       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 1; i <= NUM_FIFOS; i++) begin
            c = (int'(last_grant) + i) % NUM_FIFOS;
            if (!sel_vld && !empty_fifo[c]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(c);
            end
        end
    end
`endif

    assign grant   = grant_ok && sel_vld;
    assign sel_dat = data_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign pop     = grant ? (NUM_FIFOS'(1) << sel_idx) : '0;
    assign arb_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_DISABLED;
            push_out  <= 1'b0;
            data_out  <= '0;
            grant_idx <= '0;
`ifdef ARB_STRICT_PRIO_EN
            last_hi   <= IDX_W'(HALF - 1);
            last_lo   <= IDX_W'(NUM_FIFOS - 1);
`else
            last_grant <= IDX_W'(NUM_FIFOS - 1);
`endif
        end else begin
            // Loss of enable outranks backpressure in every state.
            case (state)
                ST_DISABLED: if (enable) state <= ST_RUN;
                ST_RUN: begin
                    if (!enable)              state <= ST_DISABLED;
                    else if (almost_full_out) state <= ST_STALL;
                end
                ST_STALL: begin
                    if (!enable)               state <= ST_DISABLED;
                    else if (!almost_full_out) state <= ST_RUN;
                end
                default: state <= ST_DISABLED;
            endcase

            // The word popped this cycle is pushed next cycle regardless of
            // where the FSM goes, so no in-flight data is ever dropped.
            push_out <= grant;
            if (grant) begin
                data_out  <= sel_dat;
                grant_idx <= sel_idx;
`ifdef ARB_STRICT_PRIO_EN
                if (int'(sel_idx) < HALF) last_hi <= sel_idx;
                else                      last_lo <= sel_idx;
`else
                last_grant <= sel_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Purpose : directed self-checking bench for vc_rr_arbiter (8 FIFOs, 10-bit words).
// Latency : checks pop in the grant cycle and push/data one cycle later.
// Backpressure: exercises almost_full stall, enable drop and mid-transfer reset.

module tb_vc_rr_arbiter;

    localparam int N  = 8;
    localparam int DW = 10;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [N-1:0]      empty_fifo;
    logic [N*DW-1:0]   data_in;
    logic              almost_full_out;
    logic [N-1:0]      pop;
    logic              push_out;
    logic [DW-1:0]     data_out;
    logic [IW-1:0]     grant_idx;
    logic [1:0]        arb_state;

    int n_vec = 0;
    int n_bad = 0;

    vc_rr_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .empty_fifo      (empty_fifo),
        .data_in         (data_in),
        .almost_full_out (almost_full_out),
        .pop             (pop),
        .push_out        (push_out),
        .data_out        (data_out),
        .grant_idx       (grant_idx),
        .arb_state       (arb_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered push that follows a grant to FIFO k.
    task automatic chk_push(input string tag, input int k);
        chk({tag, "_push"}, 32'(push_out), 32'd1);
        chk({tag, "_data"}, 32'(data_out), 32'(k + 10));
        chk({tag, "_gidx"}, 32'(grant_idx), 32'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_a [4];
        int seq_b [4];
        int cnt1, cnt6, k;

        reset           = 1'b1;
        enable          = 1'b1;
        empty_fifo      = 8'h00;
        almost_full_out = 1'b0;
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = DW'(i + 10);

        // ---- reset held two cycles ----
        tick();
        tick();
        chk("rst_state", 32'(arb_state), 32'd0);
        chk("rst_push",  32'(push_out),  32'd0);
        chk("rst_data",  32'(data_out),  32'd0);
        chk("rst_gidx",  32'(grant_idx), 32'd0);
        chk("rst_pop",   32'(pop),       32'd0);
        reset = 1'b0;
        tick();
        chk("run_state", 32'(arb_state), 32'd1);
        chk("run_push0", 32'(push_out),  32'd0);

        // ---- all FIFOs non-empty: 10 grants, 0..7,0,1 ----
        for (int g = 0; g < 10; g++) begin
            #1;
            chk("rr_pop", 32'(pop), 32'd1 << (g % 8));
            tick();
            chk_push("rr", g % 8);
        end

        // ---- only FIFOs 2 and 5 non-empty: 2,5,2,5 ----
        empty_fifo = 8'b1101_1011;
        for (int g = 0; g < 4; g++) begin
            k = (g % 2 == 0) ? 2 : 5;
            #1;
            chk("two_pop", 32'(pop), 32'd1 << k);
            tick();
            chk_push("two", k);
        end

        // ---- backpressure right after a grant to FIFO 3 ----
        empty_fifo = ~8'h08;
        #1;
        chk("bp_pop3", 32'(pop), 32'h08);
        tick();
        almost_full_out = 1'b1;
        empty_fifo      = 8'h00;
        chk_push("bp_inflight", 3);
        #1;
        chk("bp_pop_blk", 32'(pop), 32'd0);
        tick();
        chk("bp_state", 32'(arb_state), 32'd2);
        chk("bp_nopush", 32'(push_out), 32'd0);
        chk("bp_hold",  32'(data_out),  32'd13);
        chk("bp_pop_stall", 32'(pop), 32'd0);
        tick();
        chk("bp_pop_stall2", 32'(pop), 32'd0);
        almost_full_out = 1'b0;
        #1;
        chk("bp_pop_exit", 32'(pop), 32'd0);
        tick();
        chk("bp_resume", 32'(arb_state), 32'd1);
        chk("bp_nopush2", 32'(push_out), 32'd0);
        #1;
        chk("bp_next4", 32'(pop), 32'h10);
        tick();
        chk_push("bp_p4", 4);

        // ---- enable dropped after a pop to FIFO 6 ----
        empty_fifo = ~8'h40;
        #1;
        chk("en_pop6", 32'(pop), 32'h40);
        tick();
        enable     = 1'b0;
        empty_fifo = 8'h00;
        chk_push("en_inflight", 6);
        #1;
        chk("en_pop_off", 32'(pop), 32'd0);
        tick();
        chk("en_state", 32'(arb_state), 32'd0);
        chk("en_nopush", 32'(push_out), 32'd0);
        chk("en_pop_dis", 32'(pop), 32'd0);
        enable = 1'b1;
        #1;
        chk("en_pop_dis2", 32'(pop), 32'd0);
        tick();
        chk("en_state_run", 32'(arb_state), 32'd1);
        #1;
        chk("en_next7", 32'(pop), 32'h80);
        tick();
        chk_push("en_p7", 7);

        // ---- FIFOs 1 and 6, two words each, flags drop the cycle after pop ----
`ifdef ARB_STRICT_PRIO_EN
        seq_a = '{1, 1, 6, 6};
`else
        seq_a = '{1, 6, 1, 6};
`endif
        seq_b = seq_a;
        cnt1 = 2;
        cnt6 = 2;
        empty_fifo = ~8'h42;
        for (int g = 0; g < 4; g++) begin
            k = seq_b[g];
            #1;
            chk("pair_pop", 32'(pop), 32'd1 << k);
            tick();
            if (k == 1) cnt1--; else cnt6--;
            empty_fifo[1] = (cnt1 == 0);
            empty_fifo[6] = (cnt6 == 0);
            chk_push("pair", k);
        end
        #1;
        chk("pair_drained", 32'(pop), 32'd0);
        tick();
        chk("pair_nopush", 32'(push_out), 32'd0);

        // ---- reset in the middle of a transfer ----
        empty_fifo = 8'h00;
        #1;
        chk("mr_pop7", 32'(pop), 32'h80);
        tick();
        chk_push("mr_inflight", 7);
        reset = 1'b1;
        tick();
        chk("mr_push",  32'(push_out),  32'd0);
        chk("mr_data",  32'(data_out),  32'd0);
        chk("mr_gidx",  32'(grant_idx), 32'd0);
        chk("mr_state", 32'(arb_state), 32'd0);
        chk("mr_pop",   32'(pop),       32'd0);
        reset = 1'b0;
        tick();
        #1;
        chk("mr_first0", 32'(pop), 32'h01);
        tick();
        chk_push("mr_p0", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
